// File: rtl/sram_cache_pkg.sv
// Shared types and constants for the direct-mapped write-through cache controller.
// Defaults here match the controller's default parameters.
package sram_cache_pkg;

  localparam int ADDR_WIDTH_DEF  = 4;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int LINES_DEF       = 4;
  localparam int INDEX_WIDTH_DEF = $clog2(LINES_DEF);
  localparam int TAG_WIDTH_DEF   = ADDR_WIDTH_DEF - INDEX_WIDTH_DEF;
  localparam int CNT_WIDTH       = 16;

  typedef enum logic [2:0] {
    IDLE,
    FILL0,
    FILL1,
    WRITE,
    RESP
  } state_t;

  typedef struct packed {
    logic                     valid;
    logic [TAG_WIDTH_DEF-1:0] tag;
    logic [DATA_WIDTH_DEF-1:0] data;
  } line_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sram_cache_lines.sv
// Line storage for the cache: valid/tag/data per line, combinational lookup,
// single write port and global invalidate. Only the valid bits are reset.
module sram_cache_lines #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 4,
  localparam int INDEX_WIDTH = $clog2(LINES),
  localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  invalidate_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] hit_data_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  logic [LINES-1:0]      valid_w;
  logic [TAG_WIDTH-1:0]  tag_w  [LINES];
  logic [DATA_WIDTH-1:0] data_w [LINES];

  logic [INDEX_WIDTH-1:0] lk_idx;
  logic [TAG_WIDTH-1:0]   lk_tag;
  logic [INDEX_WIDTH-1:0] wr_idx;
  logic [TAG_WIDTH-1:0]   wr_tag;

  assign lk_idx = lookup_addr_i[INDEX_WIDTH-1:0];
  assign lk_tag = lookup_addr_i[ADDR_WIDTH-1:INDEX_WIDTH];
  assign wr_idx = wr_addr_i[INDEX_WIDTH-1:0];
  assign wr_tag = wr_addr_i[ADDR_WIDTH-1:INDEX_WIDTH];

  assign hit_o      = valid_w[lk_idx] && (tag_w[lk_idx] == lk_tag);
  assign hit_data_o = data_w[lk_idx];

  for (genvar gi = 0; gi < LINES; gi++) begin : g_line
    logic                  valid_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  sel;

    assign sel = wr_en_i && (wr_idx == INDEX_WIDTH'(gi));

    // Invalidate takes priority; the controller never requests both at once.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
      end else if (invalidate_i) begin
        valid_q <= 1'b0;
      end else if (sel) begin
        valid_q <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (sel) begin
        tag_q  <= wr_tag;
        data_q <= wr_data_i;
      end
    end

    assign valid_w[gi] = valid_q;
    assign tag_w[gi]   = tag_q;
    assign data_w[gi]  = data_q;
  end

endmodule

// File: rtl/sram_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache in front of a single-port
// sram. Owns the request FSM, the sram port drive and the hit/miss counters.
module sram_cache_ctrl
  import sram_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LINES      = LINES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_re_q;
  logic                  mem_we_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic [CNT_WIDTH-1:0]  hit_cnt_q;
  logic [CNT_WIDTH-1:0]  miss_cnt_q;

  logic                  handshake;
  logic                  invalidate;
  logic [ADDR_WIDTH-1:0] lookup_addr;
  logic                  lk_hit;
  logic [DATA_WIDTH-1:0] lk_data;
  logic                  line_wr_en;
  logic [DATA_WIDTH-1:0] line_wr_data;

  assign req_ready  = (state_q == IDLE) && !flush;
  assign handshake  = req_valid && req_ready;
  assign invalidate = (state_q == IDLE) && flush;

  // mem_addr_q holds the accepted request address for the rest of the operation.
  assign lookup_addr  = (state_q == IDLE) ? req_addr : mem_addr_q;
  assign line_wr_en   = (state_q == FILL1) || ((state_q == WRITE) && lk_hit);
  assign line_wr_data = (state_q == FILL1) ? mem_rdata : mem_wdata_q;

  sram_cache_lines #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .LINES     (LINES)
  ) u_lines (
    .clk          (clk),
    .rst_n        (rst_n),
    .invalidate_i (invalidate),
    .lookup_addr_i(lookup_addr),
    .hit_o        (lk_hit),
    .hit_data_o   (lk_data),
    .wr_en_i      (line_wr_en),
    .wr_addr_i    (mem_addr_q),
    .wr_data_i    (line_wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            mem_addr_q <= req_addr;
            if (req_we) begin
              mem_we_q     <= 1'b1;
              mem_wdata_q  <= req_wdata;
              resp_rdata_q <= '0;
              state_q      <= WRITE;
            end else if (lk_hit) begin
              resp_rdata_q <= lk_data;
              resp_valid_q <= 1'b1;
              hit_cnt_q    <= sat_inc(hit_cnt_q);
              state_q      <= RESP;
            end else begin
              mem_re_q   <= 1'b1;
              miss_cnt_q <= sat_inc(miss_cnt_q);
              state_q    <= FILL0;
            end
          end
        end
        FILL0: begin
          state_q <= FILL1;
        end
        FILL1: begin
          resp_rdata_q <= mem_rdata;
          mem_re_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        WRITE: begin
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          mem_re_q     <= 1'b0;
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_sram_cache_ctrl.sv
// Bench for sram_cache_ctrl: behavioural sram with backdoor preload, directed
// scenarios followed by random traffic, scoreboard-checked responses.
module tb_sram_cache_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        flush;
  logic [3:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  sram_cache_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .flush     (flush),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port sram: registered read, high-Z output when not reading.
  logic [31:0] sram_mem [16];
  logic [31:0] sram_rd;
  logic        bd_en;
  logic [3:0]  bd_addr;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_en) sram_mem[bd_addr] <= bd_data;
    else if (mem_we) sram_mem[mem_addr] <= mem_wdata;
    if (mem_re) sram_rd <= sram_mem[mem_addr];
  end
  assign mem_rdata = mem_re ? sram_rd : 'z;

  // Reference model: memory contents plus which address each line holds.
  logic [31:0] ref_mem [16];
  bit          mv [4];
  logic [1:0]  mt [4];
  int          exp_hits;
  int          exp_misses;
  logic [31:0] exp_q [$];

  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("re_we_exclusive", {31'd0, mem_re & mem_we}, 32'd0);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          chk("resp_rdata", resp_rdata, exp_q.pop_front());
        end
      end
    end
  end

  task automatic model_invalidate();
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
  endtask

  // Issues one request starting just after a rising edge; returns just after a rising edge.
  task automatic do_req(input logic we, input logic [3:0] addr, input logic [31:0] wd);
    logic [1:0] idx;
    logic [1:0] tg;
    bit         hit;
    int         lat;
    bit         exp_re;
    bit         exp_we;
    idx = addr[1:0];
    tg  = addr[3:2];
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    hit = !we && mv[idx] && (mt[idx] == tg);
    if (we) begin
      ref_mem[addr] = wd;
      exp_q.push_back(32'd0);
      lat = 2;
    end else if (hit) begin
      if (exp_hits < 65535) exp_hits++;
      exp_q.push_back(ref_mem[addr]);
      lat = 1;
    end else begin
      if (exp_misses < 65535) exp_misses++;
      mv[idx] = 1'b1;
      mt[idx] = tg;
      exp_q.push_back(ref_mem[addr]);
      lat = 3;
    end
    $display("txn %s addr=%0d wdata=%h kind=%s", we ? "WR" : "RD", addr, wd,
             we ? "write" : (hit ? "hit" : "miss"));
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      exp_re = !we && !hit && (c < lat);
      exp_we = we && (c == 1);
      chk("mem_re", {31'd0, mem_re}, {31'd0, exp_re});
      chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
      if (exp_re || exp_we) chk("mem_addr", {28'd0, mem_addr}, {28'd0, addr});
      if (exp_we) chk("mem_wdata", mem_wdata, wd);
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, c == lat});
    end
    chk("hit_cnt", {16'd0, hit_cnt}, exp_hits);
    chk("miss_cnt", {16'd0, miss_cnt}, exp_misses);
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input bit with_req);
    flush     = 1'b1;
    req_valid = with_req;
    req_we    = 1'b0;
    req_addr  = 4'd5;
    @(negedge clk);
    chk("req_ready_flush", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    model_invalidate();
    $display("txn FLUSH with_req=%0d", with_req);
    @(negedge clk);
    chk("no_resp_after_flush", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    exp_hits = 0;
    exp_misses = 0;
    model_invalidate();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    flush = 1'b0;
    bd_en = 1'b0;
    bd_addr = '0;
    bd_data = '0;

    @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    chk("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);

    // Backdoor preload while the controller is held in reset.
    for (int i = 0; i < 16; i++) begin
      bd_en   = 1'b1;
      bd_addr = 4'(i);
      bd_data = (i == 5) ? 32'hDEADBEEF : $urandom;
      ref_mem[i] = bd_data;
      @(posedge clk);
      #1;
    end
    bd_en = 1'b0;
    rst_n = 1'b1;

    do_req(1'b0, 4'd5, 32'd0);          // miss
    do_req(1'b0, 4'd5, 32'd0);          // hit
    do_req(1'b0, 4'd9, 32'd0);          // conflict miss
    do_req(1'b0, 4'd5, 32'd0);          // miss again
    chk("miss_cnt_conflict", {16'd0, miss_cnt}, 32'd3);
    do_req(1'b1, 4'd5, 32'h12345678);   // write to cached line
    do_req(1'b0, 4'd5, 32'd0);          // hit with new data
    do_req(1'b1, 4'd3, 32'hCAFEF00D);   // write, no allocate
    do_req(1'b0, 4'd3, 32'd0);          // miss, new data from memory
    do_flush(1'b1);
    do_req(1'b0, 4'd5, 32'd0);          // miss after flush

    // Reset while the fill of address 6 is in its second memory cycle.
    req_we = 1'b0;
    req_addr = 4'd6;
    req_valid = 1'b1;
    @(negedge clk);
    chk("req_ready_pre_abort", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_re", {31'd0, mem_re}, 32'd0);
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_mem_addr", {28'd0, mem_addr}, 32'd0);
    chk("abort_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    chk("abort_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    $display("txn RESET during fill of addr=6");
    model_invalidate();
    exp_hits = 0;
    exp_misses = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_req(1'b0, 4'd6, 32'd0);          // must miss: nothing was installed

    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) do_flush($urandom_range(0, 1) == 1);
      else do_req(r < 7, 4'($urandom_range(0, 15)), $urandom);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
